// File: rtl/dac_instr_queue_pkg.sv
// Shared defaults for the DAC output path (also used by pid_pipeline and the DAC controller)
// and the issue FSM encoding.
package dac_instr_queue_pkg;
  localparam int N_CHAN = 8;
  localparam int W_CHAN = 3;
  localparam int W_DATA = 16;
  localparam int W_DROP = 16;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;
endpackage

// File: rtl/dac_instr_queue_if.sv
// Pipeline-result input and DAC valid/ready output bundle of the DAC instruction queue.
interface dac_instr_queue_if #(
  parameter int W_CHAN = dac_instr_queue_pkg::W_CHAN,
  parameter int W_DATA = dac_instr_queue_pkg::W_DATA,
  parameter int W_DROP = dac_instr_queue_pkg::W_DROP
);
  logic              dv_in;
  logic [W_CHAN-1:0] chan_in;
  logic [W_DATA-1:0] data_in;
  logic              dac_rdy_in;
  logic              dac_dv_out;
  logic [W_CHAN-1:0] dac_chan_out;
  logic [W_DATA-1:0] dac_data_out;
  logic [W_DROP-1:0] drop_cnt_out;

  modport master (
    output dv_in, chan_in, data_in, dac_rdy_in,
    input  dac_dv_out, dac_chan_out, dac_data_out, drop_cnt_out
  );

  modport slave (
    input  dv_in, chan_in, data_in, dac_rdy_in,
    output dac_dv_out, dac_chan_out, dac_data_out, drop_cnt_out
  );
endinterface

// File: rtl/dac_instr_queue_rr_arbiter.sv
// Combinational round-robin picker: grants the first pending channel at or after rr_ptr,
// wrapping modulo N_CHAN.
module rr_arbiter #(
  parameter int N_CHAN = 8,
  parameter int W_CHAN = 3
) (
  input  logic [N_CHAN-1:0] pend,
  input  logic [W_CHAN-1:0] rr_ptr,
  output logic              grant_valid,
  output logic [W_CHAN-1:0] grant_idx
);

  // Scan from the farthest offset back toward rr_ptr so the nearest pending channel is kept.
  always_comb begin
    logic [W_CHAN-1:0] idx_s;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx_s       = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      idx_s       = W_CHAN'((int'(rr_ptr) + k) % N_CHAN);
      grant_valid = grant_valid | pend[idx_s];
      grant_idx   = pend[idx_s] ? idx_s : grant_idx;
    end
  end

endmodule

// File: rtl/dac_instr_queue.sv
// Per-channel latest-value buffer issuing one DAC write at a time, round-robin over pending channels.
// Define DAC_QUEUE_DROP_CNT_EN to build the overwrite (drop) counter; otherwise drop_cnt_out is 0.
module dac_instr_queue #(
  parameter int N_CHAN = dac_instr_queue_pkg::N_CHAN,
  parameter int W_CHAN = dac_instr_queue_pkg::W_CHAN,
  parameter int W_DATA = dac_instr_queue_pkg::W_DATA,
  parameter int W_DROP = dac_instr_queue_pkg::W_DROP
) (
  input logic              clk_in,
  input logic              rst_in,
  dac_instr_queue_if.slave bus
);
  import dac_instr_queue_pkg::*;

  localparam logic [W_CHAN:0]   N_CHAN_L  = (W_CHAN + 1)'(N_CHAN);
  localparam logic [W_CHAN-1:0] LAST_CHAN = W_CHAN'(N_CHAN - 1);

  state_t            state_r, state_s;
  logic [W_DATA-1:0] val_r [N_CHAN];
  logic [N_CHAN-1:0] pend_r;
  logic [W_CHAN-1:0] rr_ptr_r;
  logic [W_CHAN-1:0] chan_r;
  logic [W_DATA-1:0] data_r;
  logic              dv_r;
  logic              grant_valid_s;
  logic [W_CHAN-1:0] grant_idx_s;
  logic              wr_s, load_s, accept_s;

  rr_arbiter #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN)) u_arb (
    .pend        (pend_r),
    .rr_ptr      (rr_ptr_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Out-of-range channel indices are dropped silently.
  assign wr_s = bus.dv_in && ({1'b0, bus.chan_in} < N_CHAN_L);

  // Next-state and load/accept decode; the ready input only matters while a word is offered.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        load_s  = grant_valid_s;
        state_s = grant_valid_s ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        accept_s = bus.dac_rdy_in;
        state_s  = bus.dac_rdy_in ? S_IDLE : S_ISSUE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Pending flags, round-robin pointer and the offered word; a same-cycle write re-arms pend.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pend_r   <= '0;
      rr_ptr_r <= '0;
      chan_r   <= '0;
      data_r   <= '0;
      dv_r     <= 1'b0;
    end else begin
      if (load_s) begin
        chan_r              <= grant_idx_s;
        data_r              <= val_r[grant_idx_s];
        pend_r[grant_idx_s] <= 1'b0;
        dv_r                <= 1'b1;
      end
      if (accept_s) begin
        dv_r     <= 1'b0;
        rr_ptr_r <= (chan_r == LAST_CHAN) ? '0 : chan_r + 1'b1;
      end
      if (wr_s) pend_r[bus.chan_in] <= 1'b1;
    end
  end

  // Channel value storage; contents are only meaningful while the matching pend bit is set.
  always_ff @(posedge clk_in) begin
    if (wr_s) val_r[bus.chan_in] <= bus.data_in;
  end

`ifdef DAC_QUEUE_DROP_CNT_EN
  logic              drop_s;
  logic [W_DROP-1:0] drop_cnt_r;

  // A replaced value that was just handed to the DAC is not a drop.
  assign drop_s = wr_s && pend_r[bus.chan_in] && !(load_s && (grant_idx_s == bus.chan_in));

  // Saturating drop counter.
  always_ff @(posedge clk_in) begin
    if (!rst_in)                             drop_cnt_r <= '0;
    else if (drop_s && (drop_cnt_r != '1))   drop_cnt_r <= drop_cnt_r + 1'b1;
    else                                     drop_cnt_r <= drop_cnt_r;
  end

  assign bus.drop_cnt_out = drop_cnt_r;
`else
  assign bus.drop_cnt_out = '0;
`endif

  assign bus.dac_dv_out   = dv_r;
  assign bus.dac_chan_out = chan_r;
  assign bus.dac_data_out = data_r;

endmodule

// File: tb/tb_dac_instr_queue.sv
// Self-checking bench for dac_instr_queue: spec-level model compared every cycle plus directed
// literal checks on issue order, backpressure, overwrite, same-cycle load and reset.
module tb_dac_instr_queue;
  import dac_instr_queue_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  dac_instr_queue_if bus ();

  dac_instr_queue dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drop(int d);
`ifdef DAC_QUEUE_DROP_CNT_EN
    return d;
`else
    return 0 * d;
`endif
  endfunction

  function automatic logic [31:0] word(int c, int d);
    return 32'((c << W_DATA) | d);
  endfunction

  // Behavioural model: latest value per channel, pending set, one word in flight at most.
  logic [W_DATA-1:0] m_val [N_CHAN];
  logic [N_CHAN-1:0] m_pend;
  int                m_ptr, m_chan, m_drop, m_pick;
  logic              m_busy;
  logic [W_DATA-1:0] m_data;

  function automatic int first_pending(logic [N_CHAN-1:0] p, int from);
    for (int k = 0; k < N_CHAN; k++)
      if (p[(from + k) % N_CHAN]) return (from + k) % N_CHAN;
    return -1;
  endfunction

  always_comb m_pick = first_pending(m_pend, m_ptr);

  always @(posedge clk_in) begin
    if (!rst_in) begin
      m_pend <= '0;
      m_ptr  <= 0;
      m_busy <= 1'b0;
      m_chan <= 0;
      m_data <= '0;
      m_drop <= 0;
    end else begin
      if (m_busy) begin
        if (bus.dac_rdy_in) begin
          m_busy <= 1'b0;
          m_ptr  <= (m_chan + 1) % N_CHAN;
        end
      end else if (m_pick >= 0) begin
        m_busy         <= 1'b1;
        m_chan         <= m_pick;
        m_data         <= m_val[m_pick];
        m_pend[m_pick] <= 1'b0;
      end
      if (bus.dv_in && int'(bus.chan_in) < N_CHAN) begin
        m_val[bus.chan_in] <= bus.data_in;
        if (m_pend[bus.chan_in] && !(!m_busy && m_pick == int'(bus.chan_in))
            && m_drop < (1 << W_DROP) - 1)
          m_drop <= m_drop + 1;
        m_pend[bus.chan_in] <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (check_en) begin
      check("cmp_dv", 32'(bus.dac_dv_out), 32'(m_busy));
      if (m_busy) begin
        check("cmp_chan", 32'(bus.dac_chan_out), 32'(m_chan));
        check("cmp_data", 32'(bus.dac_data_out), 32'(m_data));
      end
      check("cmp_drop", 32'(bus.drop_cnt_out), 32'(exp_drop(m_drop)));
    end
  end

  // Log of accepted words {chan, data}.
  logic [31:0] log_q[$];
  always @(negedge clk_in) begin
    if (rst_in && bus.dac_dv_out && bus.dac_rdy_in)
      log_q.push_back(word(int'(bus.dac_chan_out), int'(bus.dac_data_out)));
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wr(int c, int d);
    bus.dv_in   = 1'b1;
    bus.chan_in = W_CHAN'(c);
    bus.data_in = W_DATA'(d);
    tick();
    bus.dv_in   = 1'b0;
  endtask

  task automatic wait_log(int n, int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_log", 32'(log_q.size()), 32'(n));
  endtask

  initial begin
    bus.dv_in      = 1'b0;
    bus.chan_in    = '0;
    bus.data_in    = '0;
    bus.dac_rdy_in = 1'b1;
    rst_in         = 1'b0;
    tick(2);
    check_en = 1'b1;
    check("rst_dv",   32'(bus.dac_dv_out),   32'd0);
    check("rst_chan", 32'(bus.dac_chan_out), 32'd0);
    check("rst_data", 32'(bus.dac_data_out), 32'd0);
    check("rst_drop", 32'(bus.drop_cnt_out), 32'd0);
    rst_in = 1'b1;
    tick();

    // Single write: offered two cycles after the pulse, for exactly one cycle.
    wr(3, 16'h1234);
    tick();
    check("single_dv",   32'(bus.dac_dv_out),   32'd1);
    check("single_chan", 32'(bus.dac_chan_out), 32'd3);
    check("single_data", 32'(bus.dac_data_out), 32'h1234);
    tick();
    check("single_dv_drop", 32'(bus.dac_dv_out), 32'd0);
    check("single_log", log_q[0], word(3, 16'h1234));

    // Burst 5,1,6 while chan 7 is stalled; rr_ptr becomes 0 on its acceptance.
    bus.dac_rdy_in = 1'b0;
    wr(7, 16'h0707);
    tick();
    check("stall_chan7", 32'(bus.dac_chan_out), 32'd7);
    wr(5, 16'h0505);
    wr(1, 16'h0101);
    wr(6, 16'h0606);
    tick(2);
    bus.dac_rdy_in = 1'b1;
    wait_log(5, 40);
    check("burst_0", log_q[1], word(7, 16'h0707));
    check("burst_1", log_q[2], word(1, 16'h0101));
    check("burst_2", log_q[3], word(5, 16'h0505));
    check("burst_3", log_q[4], word(6, 16'h0606));
    wr(0, 16'h0A0A);
    wait_log(6, 20);
    check("burst_follow", log_q[5], word(0, 16'h0A0A));

    // Backpressure with a new value for the in-flight channel mid-stall.
    bus.dac_rdy_in = 1'b0;
    wr(2, 16'h00AA);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) wr(2, 16'h00BB);
      else        tick();
      check("bp_dv",   32'(bus.dac_dv_out),   32'd1);
      check("bp_data", 32'(bus.dac_data_out), 32'h00AA);
    end
    bus.dac_rdy_in = 1'b1;
    wait_log(8, 20);
    check("bp_first",  log_q[6], word(2, 16'h00AA));
    check("bp_second", log_q[7], word(2, 16'h00BB));
    check("bp_nodrop", 32'(bus.drop_cnt_out), 32'd0);

    // Overwrite of a pending channel while the DAC is stalled on chan 1.
    bus.dac_rdy_in = 1'b0;
    wr(1, 16'h0001);
    tick();
    wr(4, 16'h1111);
    wr(4, 16'h2222);
    tick();
    check("ovw_drop", 32'(bus.drop_cnt_out), 32'(exp_drop(1)));
    bus.dac_rdy_in = 1'b1;
    wait_log(10, 20);
    check("ovw_chan1", log_q[8], word(1, 16'h0001));
    check("ovw_chan4", log_q[9], word(4, 16'h2222));
    tick(4);
    check("ovw_no_stale", 32'(log_q.size()), 32'd10);

    // Write landing in the same cycle the channel is loaded.
    wr(5, 16'h0555);
    wr(5, 16'h0666);
    wait_log(12, 20);
    check("same_old", log_q[10], word(5, 16'h0555));
    check("same_new", log_q[11], word(5, 16'h0666));
    check("same_drop", 32'(bus.drop_cnt_out), 32'(exp_drop(1)));

    // Reset during ISSUE with three channels pending.
    bus.dac_rdy_in = 1'b0;
    wr(0, 16'h0C0C);
    tick();
    check("rst2_pre_dv", 32'(bus.dac_dv_out), 32'd1);
    wr(2, 16'h0202);
    wr(3, 16'h0303);
    wr(6, 16'h0606);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("rst2_dv",   32'(bus.dac_dv_out),   32'd0);
    check("rst2_chan", 32'(bus.dac_chan_out), 32'd0);
    check("rst2_data", 32'(bus.dac_data_out), 32'd0);
    check("rst2_drop", 32'(bus.drop_cnt_out), 32'd0);
    bus.dac_rdy_in = 1'b1;
    tick(10);
    check("rst2_no_issue", 32'(log_q.size()), 32'd12);
    check("rst2_dv_idle",  32'(bus.dac_dv_out), 32'd0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_instr_queue.md
# dac_instr_queue

Per-channel output buffer between the PID processing pipeline and the DAC controller. Holds the most recent pipeline result for each channel and issues one DAC write at a time over a valid/ready handshake. Issue order is round-robin across pending channels. Absorbs bursts from the pipeline, which can produce results faster than the serial DAC can accept them. A newer value for a pending channel replaces the older one.

## Interface
Parameters:
- N_CHAN, 8, number of output channels
- W_CHAN, 3, channel index width (clog2 of N_CHAN)
- W_DATA, 16, DAC code width
- W_DROP, 16, drop counter width

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  synchronous, active-low reset
- dv_in  input  1  pipeline result valid, single-cycle pulse
- chan_in  input  W_CHAN  result channel
- data_in  input  W_DATA  result DAC code
- dac_rdy_in  input  1  DAC controller accepts the current word
- dac_dv_out  output  W=1  word valid toward DAC controller
- dac_chan_out  output  W_CHAN  channel of the offered word
- dac_data_out  output  W_DATA  offered DAC code
- drop_cnt_out  output  W_DROP  count of overwritten pending values

## Operation
- Storage:
  - Per channel: data register `val[c]` and `pend[c]` bit.
  - Write on `dv_in`: `val[chan_in] <= data_in`, `pend[chan_in] <= 1`.
  - `chan_in >= N_CHAN` is ignored: no state change, no drop count.
- Overwrite: `dv_in` to a channel with `pend` = 1 replaces the data and increments the drop counter (see Configuration).
- FSM, 2 states:
  - IDLE: if any `pend` is set, pick the first pending channel at or after `rr_ptr`, wrapping modulo N_CHAN. Load `dac_chan_out` and `dac_data_out`, clear that `pend`, go to ISSUE. If none is pending, stay in IDLE.
  - ISSUE: `dac_dv_out` = 1. On `dac_rdy_in` = 1: transfer completes, `rr_ptr <= granted + 1` (wraps N_CHAN-1 → 0), go to IDLE. Otherwise hold.
- Handshake:
  - `dac_chan_out` and `dac_data_out` are stable while `dac_dv_out` is high.
  - `dac_dv_out` is never withdrawn without acceptance, except on reset.
  - `dac_rdy_in` is ignored in IDLE.
- Simultaneous events:
  - `dv_in` to the channel being loaded in the same IDLE cycle: the loaded word is the old `val`. The write wins, so `pend` stays 1 with the new data. No drop is counted, because the old value was issued.
  - `dv_in` to the channel in flight during ISSUE: the in-flight word is unchanged. The new value becomes pending.
- Arithmetic: none on data. The drop counter saturates at 2^W_DROP-1 and does not wrap.

## Timing
- Reset, active-low, synchronous:
  - All `pend` = 0, `rr_ptr` = 0, state = IDLE.
  - `dac_dv_out` = 0, `dac_chan_out` = 0, `dac_data_out` = 0, `drop_cnt_out` = 0.
  - `val[]` need not be cleared.
- Reset mid-ISSUE abandons the word: `dac_dv_out` is 0 the cycle after the reset edge.
- Latency: `dv_in` at edge t with the queue empty and in IDLE → `pend` set at t+1 → `dac_dv_out` high from t+2.
- Throughput: one word per 2 cycles at best (ISSUE→IDLE→ISSUE), which is well above DAC serial rate.
- Capacity: N_CHAN words. The block never stalls upstream, so no `rdy` goes toward the pipeline.

## Configuration
- Macro `DAC_QUEUE_DROP_CNT_EN`.
- Defined: drop counter is implemented and drives `drop_cnt_out`.
- Undefined: no counter logic; `drop_cnt_out` is tied to 0. The port list does not change.

## Structure
- Shared parameters header or package holds:
  - FSM state encoding (`S_IDLE`, `S_ISSUE`)
  - default N_CHAN, W_CHAN and DAC W_DATA, shared with pid_pipeline and the DAC controller
- One sub-module, `rr_arbiter`:
  - Combinational round-robin picker.
  - Inputs: `pend` vector and `rr_ptr`.
  - Outputs: `grant_valid` and `grant_idx`.

## Test plan
- Single write, chan 3, data 0x1234, `dac_rdy_in` held 1 → `dac_dv_out` high 2 cycles after `dv_in`, chan 3, 0x1234, for exactly 1 cycle.
- Burst on consecutive cycles to chans 5, 1, 6, `dac_rdy_in` = 1, `rr_ptr` = 0 → issue order 1, 5, 6. A follow-up write to chan 0 then issues after 6.
- Backpressure: `dac_rdy_in` = 0 for 10 cycles while offering chan 2 value 0x00AA, with a new write 0x00BB to chan 2 mid-stall → 0x00AA is held stable until accepted. Then 0x00BB issues.
- Overwrite: two writes to chan 4 (0x1111, 0x2222) while it is pending with the DAC stalled → only 0x2222 issues. With the macro defined, `drop_cnt_out` = 1; undefined, 0.
- Write to the channel being loaded in the same cycle → the old value issues, the new value issues next, and `drop_cnt_out` is unchanged.
- Assert `rst_in` = 0 for 1 cycle during ISSUE with 3 channels pending → next cycle all outputs are 0 and no further issues occur. `chan_in` = N_CHAN is ignored.
